// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the ROM/SRAM port arbiter: state encoding,
// the captured request record and the legal access-length range.
package rom_arb_pkg;

  localparam int MIN_ACCESS_CYCLES = 3;
  localparam int MAX_ACCESS_CYCLES = 15;

  // Field widths of the captured request; the arbiter's ADDR_W/DATA_W must match.
  localparam int ROM_ADDR_W = 24;
  localparam int ROM_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SNES_ACC = 2'd1,
    MCU_ACC  = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                  we;
    logic [ROM_ADDR_W-1:0] addr;
    logic [ROM_DATA_W-1:0] wdata;
  } mem_req_t;

  // WE_N is held off for the first and last access cycle (address setup/hold).
  function automatic logic in_we_window(input int cnt, input int cycles);
    return (cnt >= 1) && (cnt <= cycles - 2);
  endfunction

endpackage

// File: rtl/rom_bus_arbiter_req_slot.sv
// One-deep request holding register: captures a request on load, drops it on
// clear (load wins when both are asserted), and reports whether one is held.
module arb_req_slot
  import rom_arb_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     load,
  input  logic     clr,
  input  mem_req_t req_in,
  output mem_req_t req_out,
  output logic     valid
);

  mem_req_t req_q, req_d;
  logic     valid_q, valid_d;

  always_comb begin
    req_d   = req_q;
    valid_d = valid_q;
    if (load) begin
      req_d   = req_in;
      valid_d = 1'b1;
    end else if (clr) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      req_q   <= req_d;
      valid_q <= valid_d;
    end
  end

  assign req_out = req_q;
  assign valid   = valid_q;

endmodule

// File: rtl/rom_bus_arbiter.sv
// Shares one external ROM/SRAM port between the SNES bus (absolute priority)
// and the MCU, generating the full SRAM access. Optional stats: ARB_STATS_EN.
module rom_bus_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ACCESS_CYCLES = 5,
  parameter int ADDR_W        = 24,
  parameter int DATA_W        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              snes_req,
  input  logic              snes_we,
  input  logic [ADDR_W-1:0] snes_addr,
  input  logic [DATA_W-1:0] snes_wdata,
  output logic [DATA_W-1:0] snes_rdata,
  output logic              snes_rdy,
  input  logic              mcu_req,
  input  logic              mcu_we,
  input  logic [ADDR_W-1:0] mcu_addr,
  input  logic [DATA_W-1:0] mcu_wdata,
  output logic [DATA_W-1:0] mcu_rdata,
  output logic              mcu_rdy,
  output logic              mcu_busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dout,
  input  logic [DATA_W-1:0] ram_din,
  output logic              ram_drive,
  output logic              ram_oe_n,
  output logic              ram_we_n
`ifdef ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [15:0]       stat_mcu_wait,
  output logic [15:0]       stat_conflict
`endif
);

  localparam int              CNT_W    = $clog2(ACCESS_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

  if (ACCESS_CYCLES < MIN_ACCESS_CYCLES || ACCESS_CYCLES > MAX_ACCESS_CYCLES) begin : g_bad_cycles
    $error("rom_bus_arbiter: ACCESS_CYCLES must be in 3..15");
  end
  if (ADDR_W != ROM_ADDR_W || DATA_W != ROM_DATA_W) begin : g_bad_widths
    $error("rom_bus_arbiter: ADDR_W/DATA_W must match rom_arb_pkg widths");
  end

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  mem_req_t          cur_q, cur_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_dout_q, ram_dout_d;
  logic              ram_drive_q, ram_drive_d;
  logic              ram_oe_n_q, ram_oe_n_d;
  logic              ram_we_n_q, ram_we_n_d;
  logic [DATA_W-1:0] snes_rdata_q, snes_rdata_d;
  logic [DATA_W-1:0] mcu_rdata_q, mcu_rdata_d;
  logic              snes_rdy_q, snes_rdy_d;
  logic              mcu_rdy_q, mcu_rdy_d;
  logic              mcu_busy_q, mcu_busy_d;

  mem_req_t snes_in, mcu_in, snes_slot, mcu_slot, snes_sel, mcu_sel;
  logic     snes_valid, mcu_valid;
  logic     snes_new, mcu_new, snes_take, mcu_take;
  logic     snes_load, snes_clr, mcu_load, mcu_clr;
  logic     last_cyc, active;

  assign snes_in = {snes_we, snes_addr, snes_wdata};
  assign mcu_in  = {mcu_we, mcu_addr, mcu_wdata};

  arb_req_slot u_snes_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (snes_load),
    .clr     (snes_clr),
    .req_in  (snes_in),
    .req_out (snes_slot),
    .valid   (snes_valid)
  );

  arb_req_slot u_mcu_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (mcu_load),
    .clr     (mcu_clr),
    .req_in  (mcu_in),
    .req_out (mcu_slot),
    .valid   (mcu_valid)
  );

  always_comb begin
    snes_new = snes_req;
    mcu_new  = mcu_req && !mcu_busy_q;
    last_cyc = (state_q != IDLE) && (cnt_q == CNT_LAST);
    // A request arriving this cycle is newer than anything held in its slot.
    snes_sel = snes_new ? snes_in : snes_slot;
    mcu_sel  = mcu_new ? mcu_in : mcu_slot;

    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_d     = cur_q;
    snes_take = 1'b0;
    mcu_take  = 1'b0;

    if (state_q != IDLE) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (state_q == IDLE || last_cyc) begin
      cnt_d = '0;
      if (snes_new || snes_valid) begin
        state_d   = SNES_ACC;
        cur_d     = snes_sel;
        snes_take = 1'b1;
      end else if (mcu_new || mcu_valid) begin
        state_d  = MCU_ACC;
        cur_d    = mcu_sel;
        mcu_take = 1'b1;
      end else begin
        state_d = IDLE;
      end
    end

    snes_load = snes_new && !snes_take;
    snes_clr  = snes_take;
    mcu_load  = mcu_new && !mcu_take;
    mcu_clr   = mcu_take;

    ram_addr_d = ram_addr_q;
    ram_dout_d = ram_dout_q;
    if (snes_take || mcu_take) begin
      ram_addr_d = cur_d.addr;
      if (cur_d.we) begin
        ram_dout_d = cur_d.wdata;
      end
    end

    // Pin controls are computed from the upcoming cycle so they come out registered.
    active      = (state_d != IDLE);
    ram_oe_n_d  = !(active && !cur_d.we);
    ram_drive_d = active && cur_d.we;
    ram_we_n_d  = !(active && cur_d.we && in_we_window(int'(cnt_d), ACCESS_CYCLES));

    snes_rdy_d = last_cyc && (state_q == SNES_ACC);
    mcu_rdy_d  = last_cyc && (state_q == MCU_ACC);

    snes_rdata_d = snes_rdata_q;
    mcu_rdata_d  = mcu_rdata_q;
    if (snes_rdy_d && !cur_q.we) begin
      snes_rdata_d = ram_din;
    end
    if (mcu_rdy_d && !cur_q.we) begin
      mcu_rdata_d = ram_din;
    end

    mcu_busy_d = mcu_busy_q;
    if (mcu_new) begin
      mcu_busy_d = 1'b1;
    end else if (mcu_rdy_d) begin
      mcu_busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cur_q        <= '0;
      ram_addr_q   <= '0;
      ram_dout_q   <= '0;
      ram_drive_q  <= 1'b0;
      ram_oe_n_q   <= 1'b1;
      ram_we_n_q   <= 1'b1;
      snes_rdata_q <= '0;
      mcu_rdata_q  <= '0;
      snes_rdy_q   <= 1'b0;
      mcu_rdy_q    <= 1'b0;
      mcu_busy_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_q        <= cur_d;
      ram_addr_q   <= ram_addr_d;
      ram_dout_q   <= ram_dout_d;
      ram_drive_q  <= ram_drive_d;
      ram_oe_n_q   <= ram_oe_n_d;
      ram_we_n_q   <= ram_we_n_d;
      snes_rdata_q <= snes_rdata_d;
      mcu_rdata_q  <= mcu_rdata_d;
      snes_rdy_q   <= snes_rdy_d;
      mcu_rdy_q    <= mcu_rdy_d;
      mcu_busy_q   <= mcu_busy_d;
    end
  end

  assign ram_addr   = ram_addr_q;
  assign ram_dout   = ram_dout_q;
  assign ram_drive  = ram_drive_q;
  assign ram_oe_n   = ram_oe_n_q;
  assign ram_we_n   = ram_we_n_q;
  assign snes_rdata = snes_rdata_q;
  assign mcu_rdata  = mcu_rdata_q;
  assign snes_rdy   = snes_rdy_q;
  assign mcu_rdy    = mcu_rdy_q;
  assign mcu_busy   = mcu_busy_q;

`ifdef ARB_STATS_EN
  logic [15:0] mcu_wait_q, mcu_wait_d;
  logic [15:0] conflict_q, conflict_d;

  // An accepted MCU request is waiting exactly while its slot is still occupied.
  always_comb begin
    mcu_wait_d = mcu_wait_q;
    conflict_d = conflict_q;
    if (stat_clr) begin
      mcu_wait_d = '0;
      conflict_d = '0;
    end else begin
      if (mcu_busy_q && mcu_valid && (mcu_wait_q != 16'hFFFF)) begin
        mcu_wait_d = mcu_wait_q + 16'd1;
      end
      if (snes_req && (state_q == MCU_ACC) && (conflict_q != 16'hFFFF)) begin
        conflict_d = conflict_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcu_wait_q <= '0;
      conflict_q <= '0;
    end else begin
      mcu_wait_q <= mcu_wait_d;
      conflict_q <= conflict_d;
    end
  end

  assign stat_mcu_wait = mcu_wait_q;
  assign stat_conflict = conflict_q;
`endif

endmodule

// File: tb/tb_rom_bus_arbiter.sv
// Self-checking bench for rom_bus_arbiter: scoreboard of expected RDY cycles
// and read data, plus per-cycle checks of the memory pin sequence.
module tb_rom_bus_arbiter;

  localparam int AC = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        snes_req = 1'b0, snes_we = 1'b0;
  logic [23:0] snes_addr = '0;
  logic [7:0]  snes_wdata = '0;
  logic [7:0]  snes_rdata;
  logic        snes_rdy;
  logic        mcu_req = 1'b0, mcu_we = 1'b0;
  logic [23:0] mcu_addr = '0;
  logic [7:0]  mcu_wdata = '0;
  logic [7:0]  mcu_rdata;
  logic        mcu_rdy, mcu_busy;
  logic [23:0] ram_addr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din = '0;
  logic        ram_drive, ram_oe_n, ram_we_n;
`ifdef ARB_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] stat_mcu_wait, stat_conflict;
`endif

  rom_bus_arbiter #(.ACCESS_CYCLES(AC), .ADDR_W(24), .DATA_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .snes_req   (snes_req),
    .snes_we    (snes_we),
    .snes_addr  (snes_addr),
    .snes_wdata (snes_wdata),
    .snes_rdata (snes_rdata),
    .snes_rdy   (snes_rdy),
    .mcu_req    (mcu_req),
    .mcu_we     (mcu_we),
    .mcu_addr   (mcu_addr),
    .mcu_wdata  (mcu_wdata),
    .mcu_rdata  (mcu_rdata),
    .mcu_rdy    (mcu_rdy),
    .mcu_busy   (mcu_busy),
    .ram_addr   (ram_addr),
    .ram_dout   (ram_dout),
    .ram_din    (ram_din),
    .ram_drive  (ram_drive),
    .ram_oe_n   (ram_oe_n),
    .ram_we_n   (ram_we_n)
`ifdef ARB_STATS_EN
    ,
    .stat_clr      (stat_clr),
    .stat_mcu_wait (stat_mcu_wait),
    .stat_conflict (stat_conflict)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;
  exp_t snes_q[$];
  exp_t mcu_q[$];
  logic [7:0] snes_last = 8'h00;
  logic [7:0] mcu_last = 8'h00;

  // Simple SRAM model on the arbiter's pins.
  logic [7:0] mem [logic [23:0]];
  always @(negedge clk) ram_din <= (!ram_oe_n && mem.exists(ram_addr)) ? mem[ram_addr] : 8'h00;
  always @(posedge clk) if (!ram_we_n && ram_drive) mem[ram_addr] = ram_dout;

  // Scoreboard: every RDY pulse must match the oldest expectation for its requester.
  always @(negedge clk) begin
    exp_t e;
    if (snes_rdy) begin
      n_assert++;
      if (snes_q.size() == 0) begin
        n_fail++;
        $display("FAIL snes_rdy_unexpected: got pulse at cycle %0d, required none", cyc);
      end else begin
        e = snes_q.pop_front();
        if (cyc != e.cyc || snes_rdata !== e.data) begin
          n_fail++;
          $display("FAIL snes_rdy: got cycle %0d data %h, required cycle %0d data %h", cyc, snes_rdata, e.cyc, e.data);
        end else begin
          $display("snes access done: cycle %0d data %h", cyc, snes_rdata);
        end
      end
    end
    if (mcu_rdy) begin
      n_assert++;
      if (mcu_q.size() == 0) begin
        n_fail++;
        $display("FAIL mcu_rdy_unexpected: got pulse at cycle %0d, required none", cyc);
      end else begin
        e = mcu_q.pop_front();
        if (cyc != e.cyc || mcu_rdata !== e.data) begin
          n_fail++;
          $display("FAIL mcu_rdy: got cycle %0d data %h, required cycle %0d data %h", cyc, mcu_rdata, e.cyc, e.data);
        end else begin
          $display("mcu access done: cycle %0d data %h", cyc, mcu_rdata);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((snes_q.size() != 0 || mcu_q.size() != 0) && n < 50) begin
      tick();
      n++;
    end
    n_assert++;
    if (snes_q.size() != 0 || mcu_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d snes and %0d mcu outstanding, required 0", snes_q.size(), mcu_q.size());
      snes_q.delete();
      mcu_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_assert++;
    if ({ram_oe_n, ram_we_n, ram_drive, snes_rdy, mcu_rdy, mcu_busy} !== 6'b110000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, required 110000", {ram_oe_n, ram_we_n, ram_drive, snes_rdy, mcu_rdy, mcu_busy});
    end
    n_assert++;
    if ({ram_addr, ram_dout, snes_rdata, mcu_rdata} !== 48'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h, required 0", {ram_addr, ram_dout, snes_rdata, mcu_rdata});
    end
    rst_n = 1'b1;
    repeat (2) tick();
    n_assert++;
    if ({ram_oe_n, ram_we_n, ram_drive, mcu_busy} !== 4'b1100) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %b, required 1100", {ram_oe_n, ram_we_n, ram_drive, mcu_busy});
    end
    $display("reset checked at cycle %0d", cyc);
  endtask

  task automatic test_snes_read();
    int t = cyc;
    mem[24'h0C8000] = 8'hA5;
    snes_req = 1'b1; snes_we = 1'b0; snes_addr = 24'h0C8000;
    snes_q.push_back('{8'hA5, t + AC + 1});
    snes_last = 8'hA5;
    tick();
    snes_req = 1'b0;
    for (int k = 0; k < AC; k++) begin
      n_assert++;
      if (ram_addr !== 24'h0C8000 || {ram_oe_n, ram_we_n, ram_drive} !== 3'b010) begin
        n_fail++;
        $display("FAIL snes_read_pins k=%0d: got addr %h oe/we/drv %b, required 0c8000 010", k, ram_addr, {ram_oe_n, ram_we_n, ram_drive});
      end
      tick();
    end
    wait_drain();
  endtask

  task automatic test_mcu_write();
    int t = cyc;
    logic exp_we_n;
    mcu_req = 1'b1; mcu_we = 1'b1; mcu_addr = 24'hE00010; mcu_wdata = 8'h3C;
    mcu_q.push_back('{mcu_last, t + AC + 1});
    tick();
    mcu_req = 1'b0; mcu_we = 1'b0;
    for (int k = 0; k < AC; k++) begin
      exp_we_n = (k >= 1 && k <= AC - 2) ? 1'b0 : 1'b1;
      n_assert++;
      if (ram_addr !== 24'hE00010 || ram_dout !== 8'h3C || {mcu_busy, ram_drive, ram_oe_n, ram_we_n} !== {3'b111, exp_we_n}) begin
        n_fail++;
        $display("FAIL mcu_write_pins k=%0d: got addr %h dout %h busy/drv/oe/we %b, required e00010 3c %b",
                 k, ram_addr, ram_dout, {mcu_busy, ram_drive, ram_oe_n, ram_we_n}, {3'b111, exp_we_n});
      end
      tick();
    end
    n_assert++;
    if (mcu_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mcu_write_busy_drop: got %b, required 0", mcu_busy);
    end
    wait_drain();
  endtask

  task automatic test_collision();
    int t = cyc;
    mem[24'h0C8001] = 8'h5A;
    snes_req = 1'b1; snes_we = 1'b0; snes_addr = 24'h0C8001;
    mcu_req = 1'b1; mcu_we = 1'b0; mcu_addr = 24'hE00010;
    snes_q.push_back('{8'h5A, t + AC + 1});
    mcu_q.push_back('{8'h3C, t + 2 * AC + 1});
    snes_last = 8'h5A;
    mcu_last = 8'h3C;
    tick();
    snes_req = 1'b0; mcu_req = 1'b0;
    n_assert++;
    if (mcu_busy !== 1'b1 || ram_addr !== 24'h0C8001) begin
      n_fail++;
      $display("FAIL collision_first: got busy %b addr %h, required 1 0c8001", mcu_busy, ram_addr);
    end
    repeat (AC) tick();
    n_assert++;
    if (ram_addr !== 24'hE00010 || ram_oe_n !== 1'b0) begin
      n_fail++;
      $display("FAIL collision_no_gap: got addr %h oe_n %b, required e00010 0", ram_addr, ram_oe_n);
    end
    wait_drain();
`ifdef ARB_STATS_EN
    n_assert++;
    if (stat_mcu_wait !== 16'd5) begin
      n_fail++;
      $display("FAIL stat_mcu_wait: got %0d, required 5", stat_mcu_wait);
    end
`endif
  endtask

  task automatic test_snes_mid_mcu();
    int t = cyc;
    mcu_req = 1'b1; mcu_we = 1'b1; mcu_addr = 24'hE00020; mcu_wdata = 8'h77;
    mcu_q.push_back('{mcu_last, t + AC + 1});
    tick();
    mcu_req = 1'b0; mcu_we = 1'b0;
    tick();
    snes_req = 1'b1; snes_we = 1'b0; snes_addr = 24'h0C8000;
    snes_q.push_back('{8'hA5, cyc + 9});
    snes_last = 8'hA5;
    tick();
    snes_req = 1'b0;
    for (int k = 2; k < AC; k++) begin
      n_assert++;
      if (ram_addr !== 24'hE00020 || ram_drive !== 1'b1 || ram_we_n !== ((k <= AC - 2) ? 1'b0 : 1'b1)) begin
        n_fail++;
        $display("FAIL mid_mcu_unaltered k=%0d: got addr %h drv %b we_n %b, required e00020 1 %b",
                 k, ram_addr, ram_drive, ram_we_n, (k <= AC - 2) ? 1'b0 : 1'b1);
      end
      tick();
    end
    n_assert++;
    if (ram_addr !== 24'h0C8000 || ram_oe_n !== 1'b0 || ram_drive !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_snes_start: got addr %h oe_n %b drv %b, required 0c8000 0 0", ram_addr, ram_oe_n, ram_drive);
    end
`ifdef ARB_STATS_EN
    n_assert++;
    if (stat_conflict !== 16'd1) begin
      n_fail++;
      $display("FAIL stat_conflict: got %0d, required 1", stat_conflict);
    end
`endif
    wait_drain();
    n_assert++;
    if (mem.exists(24'hE00020) ? (mem[24'hE00020] !== 8'h77) : 1'b1) begin
      n_fail++;
      $display("FAIL mid_mcu_write_data: got no write of 77 at e00020, required 77");
    end
  endtask

  task automatic test_reset_mid_access();
    int t;
    snes_req = 1'b1; snes_we = 1'b0; snes_addr = 24'h0C8000;
    tick();
    snes_req = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    n_assert++;
    if ({ram_oe_n, ram_we_n, ram_drive, snes_rdy, mcu_busy} !== 5'b11000 || ram_addr !== 24'h0 || snes_rdata !== 8'h00 || mcu_rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset: got ctrl %b addr %h srd %h mrd %h, required 11000 0 0 0",
               {ram_oe_n, ram_we_n, ram_drive, snes_rdy, mcu_busy}, ram_addr, snes_rdata, mcu_rdata);
    end
    snes_last = 8'h00;
    mcu_last = 8'h00;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    n_assert++;
    if (ram_oe_n !== 1'b1 || snes_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_drops_req: got oe_n %b rdy %b, required 1 0", ram_oe_n, snes_rdy);
    end
    t = cyc;
    mcu_req = 1'b1; mcu_we = 1'b0; mcu_addr = 24'hE00010;
    mcu_q.push_back('{8'h3C, t + AC + 1});
    mcu_last = 8'h3C;
    tick();
    mcu_req = 1'b0;
    wait_drain();
  endtask

  task automatic test_mcu_held();
    int t = cyc;
    mcu_req = 1'b1; mcu_we = 1'b0; mcu_addr = 24'h0C8001;
    mcu_q.push_back('{8'h5A, t + AC + 1});
    mcu_q.push_back('{8'h5A, t + 2 * AC + 2});
    mcu_last = 8'h5A;
    tick();
    n_assert++;
    if (mcu_busy !== 1'b1) begin n_fail++; $display("FAIL held_busy_first: got %b, required 1", mcu_busy); end
    repeat (AC - 1) tick();
    n_assert++;
    if (mcu_busy !== 1'b1) begin n_fail++; $display("FAIL held_busy_last: got %b, required 1", mcu_busy); end
    tick();
    n_assert++;
    if (mcu_busy !== 1'b0) begin n_fail++; $display("FAIL held_busy_gap: got %b, required 0", mcu_busy); end
    tick();
    n_assert++;
    if (mcu_busy !== 1'b1) begin n_fail++; $display("FAIL held_busy_second: got %b, required 1", mcu_busy); end
    mcu_req = 1'b0;
    wait_drain();
    n_assert++;
    if (mcu_busy !== 1'b0 || ram_oe_n !== 1'b1) begin
      n_fail++;
      $display("FAIL held_release: got busy %b oe_n %b, required 0 1", mcu_busy, ram_oe_n);
    end
  endtask

`ifdef ARB_STATS_EN
  task automatic test_stat_clr();
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    n_assert++;
    if (stat_mcu_wait !== 16'd0 || stat_conflict !== 16'd0) begin
      n_fail++;
      $display("FAIL stat_clr: got %0d %0d, required 0 0", stat_mcu_wait, stat_conflict);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_snes_read();
    test_mcu_write();
    test_collision();
    test_snes_mid_mcu();
`ifdef ARB_STATS_EN
    test_stat_clr();
`endif
    test_reset_mid_access();
    test_mcu_held();
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
